// File: rtl/fifo_flags.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds, occupancy count,
// sticky overflow/underflow flags and synchronous flush. Define FIFO_FWFT_EN for first-word fall-through.
module fifo_flags #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned DEPTH         = 256,
  parameter int unsigned AFULL_THRESH  = DEPTH - 16,
  parameter int unsigned AEMPTY_THRESH = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   data_out,
  input  logic                    flush,
  input  logic                    clr_err,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

  // Parameter legality checks at elaboration
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_flags: DEPTH must be a power of two >= 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("fifo_flags: AFULL_THRESH must be in 1..DEPTH");
  end
  if (AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("fifo_flags: AEMPTY_THRESH must be in 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  ovf_set;
  logic                  unf_set;
  logic [CW-1:0]         count_nxt;

  // Accept decisions; flush suppresses both ports and any error detection
  always_comb begin
    rd_acc    = rd_en & ~empty & ~flush;
    wr_acc    = wr_en & (~full | rd_en) & ~flush;
    ovf_set   = wr_en & ~wr_acc & ~flush;
    unf_set   = rd_en & ~rd_acc & ~flush;
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else if (wr_acc && !rd_acc) begin
      count_nxt = count + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_nxt = count - CW'(1);
    end
  end

  // Pointers, occupancy and status flags (flags registered from the next count)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
        if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      end
      count        <= count_nxt;
      full         <= (count_nxt == DEPTH_C);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AFULL_C);
      almost_empty <= (count_nxt <= AEMPTY_C);
    end
  end

  // Sticky error flags; a new event wins over a same-cycle clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_set | (overflow & ~clr_err);
      underflow <= unf_set | (underflow & ~clr_err);
    end
  end

  always_ff @(posedge clock) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  assign data_out = mem[rd_ptr];
`else
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out <= '0;
    end else if (rd_acc) begin
      data_out <= mem[rd_ptr];
    end
  end
`endif

endmodule
